// File: rtl/icache_dataram_arbiter_pkg.sv
// Shared icache data-array types and widths.
// Used by the data-array arbiter and its response FIFO.
package toy_pack;

  localparam int ICACHE_INDEX_WIDTH     = 6;
  localparam int ICACHE_REQ_TXNID_WIDTH = 4;
  localparam int MSHR_ENTRY_INDEX_WIDTH = 3;
  localparam int ICACHE_DATA_WIDTH      = 512;

  typedef struct packed {
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
    logic [ICACHE_DATA_WIDTH-1:0]      data;
  } dataram_rsp_t;

  typedef enum logic [1:0] {
    G_IDLE,
    G_RD,
    G_WR
  } dataram_grant_t;

endpackage

// File: rtl/icache_dataram_arbiter_if.sv
// Bundle of read/write request, RAM and response signals
// around the icache data-array arbiter.
interface icache_dataram_arbiter_if
  import toy_pack::*;
#(
  parameter int INDEX_WIDTH     = ICACHE_INDEX_WIDTH,
  parameter int TXNID_WIDTH     = ICACHE_REQ_TXNID_WIDTH,
  parameter int ENTRY_IDX_WIDTH = MSHR_ENTRY_INDEX_WIDTH
);
  localparam int DW = ICACHE_DATA_WIDTH;

  logic                       rd_req_vld;
  logic                       rd_req_rdy;
  logic [INDEX_WIDTH-1:0]     rd_req_index;
  logic                       rd_req_way;
  logic [TXNID_WIDTH-1:0]     rd_req_txnid;

  logic                       wr_req_vld;
  logic                       wr_req_rdy;
  logic [INDEX_WIDTH-1:0]     wr_req_index;
  logic                       wr_req_way;
  logic [ENTRY_IDX_WIDTH-1:0] wr_req_entry_idx;
  logic [DW-1:0]              wr_req_data;

  logic                       ram_en;
  logic                       ram_wr_en;
  logic [INDEX_WIDTH:0]       ram_addr;
  logic [DW-1:0]              ram_wdata;
  logic [DW-1:0]              ram_rdata;

  logic                       rsp_vld;
  logic                       rsp_rdy;
  logic [TXNID_WIDTH-1:0]     rsp_txnid;
  logic [DW-1:0]              rsp_data;

  logic                       wr_done_vld;
  logic [ENTRY_IDX_WIDTH-1:0] wr_done_entry_idx;

  modport slave (
    input  rd_req_vld, rd_req_index,
    input  rd_req_way, rd_req_txnid,
    output rd_req_rdy,
    input  wr_req_vld, wr_req_index,
    input  wr_req_way, wr_req_entry_idx,
    input  wr_req_data,
    output wr_req_rdy,
    output ram_en, ram_wr_en,
    output ram_addr, ram_wdata,
    input  ram_rdata,
    output rsp_vld, rsp_txnid, rsp_data,
    input  rsp_rdy,
    output wr_done_vld, wr_done_entry_idx
  );

  modport master (
    output rd_req_vld, rd_req_index,
    output rd_req_way, rd_req_txnid,
    input  rd_req_rdy,
    output wr_req_vld, wr_req_index,
    output wr_req_way, wr_req_entry_idx,
    output wr_req_data,
    input  wr_req_rdy,
    input  ram_en, ram_wr_en,
    input  ram_addr, ram_wdata,
    output ram_rdata,
    input  rsp_vld, rsp_txnid, rsp_data,
    output rsp_rdy,
    input  wr_done_vld, wr_done_entry_idx
  );

endinterface

// File: rtl/icache_dataram_arbiter_rsp_fifo.sv
// Circular response FIFO holding {txnid, line} for
// granted reads until upstream accepts them.
module icache_dataram_rsp_fifo
  import toy_pack::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  dataram_rsp_t push_data,
  input  logic         pop,
  output dataram_rsp_t head,
  output logic [CW-1:0] occ,
  output logic         empty,
  output logic         full
);

  dataram_rsp_t    mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   cnt;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Line storage; no reset needed, guarded by occ.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  assign head  = mem[rptr];
  assign occ   = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/icache_dataram_arbiter.sv
// Arbitrates the single-port icache data array between
// hit reads and linefill writes (perf: ICACHE_DATARAM_ARB_PERF_EN).
module icache_dataram_arbiter
  import toy_pack::*;
#(
  parameter int INDEX_WIDTH     = ICACHE_INDEX_WIDTH,
  parameter int TXNID_WIDTH     = ICACHE_REQ_TXNID_WIDTH,
  parameter int ENTRY_IDX_WIDTH = MSHR_ENTRY_INDEX_WIDTH,
  parameter int STARVE_MAX      = 4,
  parameter int RSP_DEPTH       = 4
) (
  input  logic clk,
  input  logic rst,
  icache_dataram_arbiter_if.slave bus
`ifdef ICACHE_DATARAM_ARB_PERF_EN
  ,
  output logic [31:0] perf_rd_grant_cnt,
  output logic [31:0] perf_wr_grant_cnt,
  output logic [31:0] perf_rd_stall_cnt
`endif
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  dataram_grant_t             state_q;
  dataram_grant_t             state_d;
  logic [3:0]                 starve_q;
  logic [3:0]                 starve_d;
  logic [TXNID_WIDTH-1:0]     txnid_q;
  logic [ENTRY_IDX_WIDTH-1:0] entry_q;

  logic          rd_elig;
  logic          rd_win;
  logic          wr_win;
  logic          inflight;
  logic [CW-1:0] occ;
  logic          fifo_empty;
  logic          fifo_full;
  dataram_rsp_t  fifo_in;
  dataram_rsp_t  fifo_head;

  assign inflight = (state_q == G_RD);
  assign rd_elig  = !rst && bus.rd_req_vld && !fifo_full
                 && (int'(occ) + int'(inflight) < RSP_DEPTH);
  assign wr_win   = !rst && bus.wr_req_vld
                 && !(rd_elig && starve_q == 4'(STARVE_MAX));
  assign rd_win   = rd_elig && !wr_win;

  // Grant decode, RAM drive, next grant state and starvation.
  always_comb begin
    state_d        = G_IDLE;
    starve_d       = starve_q;
    bus.ram_en     = 1'b0;
    bus.ram_wr_en  = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;
    bus.wr_req_rdy = wr_win;
    bus.rd_req_rdy = rd_win;
    unique case (1'b1)
      wr_win: begin
        state_d       = G_WR;
        bus.ram_en    = 1'b1;
        bus.ram_wr_en = 1'b1;
        bus.ram_addr  = {bus.wr_req_index, bus.wr_req_way};
        bus.ram_wdata = bus.wr_req_data;
      end
      rd_win: begin
        state_d      = G_RD;
        bus.ram_en   = 1'b1;
        bus.ram_addr = {bus.rd_req_index, bus.rd_req_way};
      end
      default: ;
    endcase
    if (!rd_elig || rd_win)
      starve_d = '0;
    else if (starve_q != 4'(STARVE_MAX))
      starve_d = starve_q + 1'b1;
  end

  // Grant state plus the ids carried to the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= G_IDLE;
      starve_q <= '0;
      txnid_q  <= '0;
      entry_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (rd_win) txnid_q <= bus.rd_req_txnid;
      if (wr_win) entry_q <= bus.wr_req_entry_idx;
    end
  end

  assign fifo_in = '{txnid: txnid_q, data: bus.ram_rdata};

  icache_dataram_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (state_q == G_RD),
    .push_data (fifo_in),
    .pop       (bus.rsp_vld && bus.rsp_rdy),
    .head      (fifo_head),
    .occ       (occ),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.rsp_vld   = !fifo_empty;
  assign bus.rsp_txnid = fifo_empty ? '0 : fifo_head.txnid;
  assign bus.rsp_data  = fifo_empty ? '0 : fifo_head.data;

  assign bus.wr_done_vld       = (state_q == G_WR);
  assign bus.wr_done_entry_idx =
    (state_q == G_WR) ? entry_q : '0;

`ifdef ICACHE_DATARAM_ARB_PERF_EN
  // Free-running wrapping event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rd_grant_cnt <= '0;
      perf_wr_grant_cnt <= '0;
      perf_rd_stall_cnt <= '0;
    end else begin
      if (rd_win)
        perf_rd_grant_cnt <= perf_rd_grant_cnt + 1'b1;
      if (wr_win)
        perf_wr_grant_cnt <= perf_wr_grant_cnt + 1'b1;
      if (bus.rd_req_vld && !bus.rd_req_rdy)
        perf_rd_stall_cnt <= perf_rd_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dataram_arbiter.sv
// Bench for icache_dataram_arbiter: directed scenarios
// plus random traffic against a transaction-level model.
module tb_icache_dataram_arbiter;
  import toy_pack::*;

  localparam int IW    = ICACHE_INDEX_WIDTH;
  localparam int TW    = ICACHE_REQ_TXNID_WIDTH;
  localparam int EW    = MSHR_ENTRY_INDEX_WIDTH;
  localparam int SMAX  = 4;
  localparam int DEPTH = 4;
  localparam int NA    = 2 ** (IW + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_dataram_arbiter_if #(
    .INDEX_WIDTH(IW), .TXNID_WIDTH(TW),
    .ENTRY_IDX_WIDTH(EW)
  ) bus ();

  icache_dataram_arbiter #(
    .INDEX_WIDTH(IW), .TXNID_WIDTH(TW),
    .ENTRY_IDX_WIDTH(EW),
    .STARVE_MAX(SMAX), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [511:0] pat(input int a);
    logic [511:0] r;
    for (int k = 0; k < 16; k++)
      r[k*32 +: 32] = 32'hC0DE_0000 ^ (a * 32'h9E37) ^ k;
    return r;
  endfunction

  // Data array macro: 1-cycle read latency.
  logic [511:0] ram [NA];
  bit           ram_w [NA];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_wr_en) begin
        ram[bus.ram_addr]   <= bus.ram_wdata;
        ram_w[bus.ram_addr] <= 1'b1;
      end else begin
        bus.ram_rdata <= ram_w[bus.ram_addr]
          ? ram[bus.ram_addr] : pat(int'(bus.ram_addr));
      end
    end
  end

  // Transaction-level reference model.
  typedef struct {
    logic [TW-1:0] t;
    logic [511:0]  d;
  } exp_t;
  exp_t          q[$];
  logic [511:0]  ref_mem [int];
  bit            rd_last;
  int            starve;
  bit            wd_pend;
  logic [EW-1:0] wd_entry;
  int            total = 0;
  int            bad = 0;

  logic          o_rd, o_wr, o_vld, o_wd;
  logic [TW-1:0] o_tid;
  logic [EW-1:0] o_ent;
  logic [511:0]  o_dat;

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  task automatic drv_rd(input bit v, input int idx,
                        input bit way, input int tid);
    bus.rd_req_vld   = v;
    bus.rd_req_index = IW'(idx);
    bus.rd_req_way   = way;
    bus.rd_req_txnid = TW'(tid);
  endtask

  task automatic drv_wr(input bit v, input int idx,
                        input bit way, input int e);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
    bus.wr_req_vld       = v;
    bus.wr_req_index     = IW'(idx);
    bus.wr_req_way       = way;
    bus.wr_req_entry_idx = EW'(e);
    bus.wr_req_data      = d;
  endtask

  // One cycle: check outputs against the model, then
  // commit what the model says happens at the edge.
  task automatic step();
    bit elig, ew, er, fv;
    int fcnt, ra, wa;
    #1;
    if (rst) begin
      q.delete();
      rd_last = 0;
      starve  = 0;
      wd_pend = 0;
    end
    elig = !rst && bus.rd_req_vld && q.size() < DEPTH;
    ew = !rst && bus.wr_req_vld
      && !(elig && starve == SMAX);
    er = elig && !ew;
    ra = int'({bus.rd_req_index, bus.rd_req_way});
    wa = int'({bus.wr_req_index, bus.wr_req_way});
    o_rd  = bus.rd_req_rdy;
    o_wr  = bus.wr_req_rdy;
    o_vld = bus.rsp_vld;
    o_tid = bus.rsp_txnid;
    o_dat = bus.rsp_data;
    o_wd  = bus.wr_done_vld;
    o_ent = bus.wr_done_entry_idx;
    chk("rd_rdy", bus.rd_req_rdy, er);
    chk("wr_rdy", bus.wr_req_rdy, ew);
    chk("ram_en", bus.ram_en, er | ew);
    if (ew) begin
      chk("ram_wr_en", bus.ram_wr_en, 1);
      chk("ram_waddr", bus.ram_addr, wa);
      chk("ram_wdata", bus.ram_wdata, bus.wr_req_data);
    end else if (er) begin
      chk("ram_rd_en", bus.ram_wr_en, 0);
      chk("ram_raddr", bus.ram_addr, ra);
    end else begin
      chk("ram_wdata_idle", bus.ram_wdata, 0);
    end
    chk("wr_done", bus.wr_done_vld, wd_pend);
    if (wd_pend) chk("wr_done_idx", bus.wr_done_entry_idx, wd_entry);
    fcnt = q.size() - int'(rd_last);
    fv = fcnt > 0;
    chk("rsp_vld", bus.rsp_vld, fv);
    if (fv) begin
      chk("rsp_txnid", bus.rsp_txnid, q[0].t);
      chk("rsp_data", bus.rsp_data, q[0].d);
    end
    if (rst) begin
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_txnid", bus.rsp_txnid, 0);
      chk("rst_wd_idx", bus.wr_done_entry_idx, 0);
    end
    if (fv && bus.rsp_rdy) void'(q.pop_front());
    if (er) q.push_back('{bus.rd_req_txnid, ref_rd(ra)});
    if (ew) ref_mem[wa] = bus.wr_req_data;
    wd_pend  = ew;
    wd_entry = bus.wr_req_entry_idx;
    rd_last  = er;
    if (!elig || er) starve = 0;
    else if (starve < SMAX) starve++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    drv_rd(0, 0, 0, 0);
    drv_wr(0, 0, 0, 0);
    bus.rsp_rdy = 1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic single_read(input string tag);
    logic [3:0] v;
    logic [TW-1:0] tid;
    logic [511:0]  dat;
    tid = '0;
    dat = '0;
    bus.rsp_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drv_rd(1, 5, 1, 3);
      else drv_rd(0, 0, 0, 0);
      step();
      v[i] = o_vld;
      if (i == 2) begin
        tid = o_tid;
        dat = o_dat;
      end
    end
    chk({tag, "_vld_t2"}, v, 4'b0100);
    chk({tag, "_txnid"}, tid, 3);
    chk({tag, "_data"}, dat, ref_rd(11));
  endtask

  initial begin
    logic [11:0] tv;
    logic [6:0]  wv;
    logic [4:0]  rv;
    logic [3:0]  cv;
    int n, tid;

    rst = 1'b0;
    bus.rsp_rdy = 0;
    drv_rd(0, 0, 0, 0);
    drv_wr(0, 0, 0, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    drv_rd(1, 1, 0, 1);
    drv_wr(1, 2, 0, 1);
    step();
    step();
    drv_rd(0, 0, 0, 0);
    drv_wr(0, 0, 0, 0);
    rst = 1'b0;
    step();

    single_read("single");

    // Collision: write first, read next cycle.
    idle(2);
    drv_rd(1, 4, 1, 7);
    drv_wr(1, 4, 1, 2);
    step();
    cv[1:0] = {o_rd, o_wr};
    drv_wr(0, 0, 0, 0);
    step();
    cv[3:2] = {o_rd, o_wr};
    chk("coll_done", {o_wd, o_ent}, {1'b1, EW'(2)});
    chk("coll_order", cv, 4'b1001);
    drv_rd(1, 4, 1, 8);
    step();
    idle(4);

    // Starvation: writes every cycle, read held.
    for (int i = 0; i < 7; i++) begin
      drv_wr(1, i, 0, i);
      if (i < 5) drv_rd(1, 3, 1, 5);
      else drv_rd(0, 0, 0, 0);
      step();
      wv[i] = o_wr;
      if (i < 5) rv[i] = o_rd;
    end
    chk("starve_rd", rv, 5'b10000);
    chk("starve_wr", wv, 7'b1101111);
    idle(4);

    // Backpressure: only DEPTH reads granted.
    bus.rsp_rdy = 0;
    n = 0;
    tid = 0;
    for (int i = 0; i < 8; i++) begin
      drv_rd(1, tid, 0, tid);
      step();
      if (o_rd) begin
        n++;
        tid++;
      end
    end
    chk("bp_grants", n, 4);
    bus.rsp_rdy = 1;
    while (tid < 6 && n < 20) begin
      drv_rd(1, tid, 0, tid);
      step();
      n++;
      if (o_rd) tid++;
    end
    chk("bp_all_granted", tid, 6);
    idle(8);
    chk("bp_drained", q.size(), 0);

    // Throughput: 8 back-to-back reads.
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drv_rd(1, 20 + i, 1, i);
      else drv_rd(0, 0, 0, 0);
      step();
      tv[i] = o_vld;
    end
    chk("tput", tv, 12'b0011_1111_1100);

    // Reset one cycle after a read grant.
    idle(2);
    drv_rd(1, 6, 0, 9);
    step();
    drv_rd(0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n += int'(o_vld);
    end
    chk("rst_no_rsp", n, 0);
    single_read("post_rst");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drv_rd($urandom_range(0, 9) < 6,
             $urandom_range(0, 3), 1'($urandom()),
             $urandom_range(0, 15));
      drv_wr($urandom_range(0, 1) == 1,
             $urandom_range(0, 3), 1'($urandom()),
             $urandom_range(0, 7));
      bus.rsp_rdy = $urandom_range(0, 9) < 7;
      step();
    end
    idle(8);
    chk("rand_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
